// File: rtl/vga_plot_scheduler.sv
// Arbitrates two pixel requesters onto the single vga_adapter write port,
// with a full-screen clear sweep that pre-empts both requesters while active.
module vga_plot_scheduler #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear_start,
    input  logic [COLOUR_W-1:0] clear_colour,
    input  logic                req0,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [COLOUR_W-1:0] col0,
    output logic                ack0,
    input  logic                req1,
    input  logic [X_W-1:0]      x1,
    input  logic [Y_W-1:0]      y1,
    input  logic [COLOUR_W-1:0] col1,
    output logic                ack1,
    output logic                busy,
    output logic                clear_done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_write
);

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [X_W-1:0]      cx;
    logic [Y_W-1:0]      cy;
    logic [COLOUR_W-1:0] clr_col;
    logic                last_grant;
    logic                start_clear;
    logic                sweep_end;
    logic [X_W-1:0]      sel_x;
    logic [Y_W-1:0]      sel_y;
    logic [COLOUR_W-1:0] sel_col;
    logic                in_bounds;

    always_comb begin
        state_next  = state;
        ack0        = 1'b0;
        ack1        = 1'b0;
        start_clear = 1'b0;
        sweep_end   = 1'b0;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_next  = CLEAR;
                    start_clear = 1'b1;
                end else if (req0 && (!req1 || last_grant)) begin
                    // last_grant == 1 means port 1 won last, so port 0 wins a tie
                    ack0 = 1'b1;
                end else if (req1) begin
                    ack1 = 1'b1;
                end
            end
            CLEAR: begin
                if (cx == X_LAST && cy == Y_LAST) begin
                    state_next = IDLE;
                    sweep_end  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_x     = ack1 ? x1 : x0;
        sel_y     = ack1 ? y1 : y0;
        sel_col   = ack1 ? col1 : col0;
        in_bounds = (sel_x <= X_LAST) && (sel_y <= Y_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cx         <= '0;
            cy         <= '0;
            clr_col    <= '0;
            last_grant <= 1'b1;
            busy       <= 1'b0;
            clear_done <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_write  <= 1'b0;
        end else begin
            state      <= state_next;
            busy       <= (state_next == CLEAR);
            clear_done <= sweep_end;
            vga_write  <= 1'b0;
            if (start_clear) begin
                clr_col <= clear_colour;
                cx      <= '0;
                cy      <= '0;
            end
            if (state == CLEAR) begin
                vga_x      <= cx;
                vga_y      <= cy;
                vga_colour <= clr_col;
                vga_write  <= 1'b1;
                if (cx == X_LAST) begin
                    cx <= '0;
                    cy <= (cy == Y_LAST) ? '0 : cy + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end else if (ack0 || ack1) begin
                // clipped pixels are still consumed and still advance round-robin
                vga_x      <= sel_x;
                vga_y      <= sel_y;
                vga_colour <= sel_col;
                vga_write  <= in_bounds;
                last_grant <= ack1;
            end
        end
    end

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Self-checking bench for vga_plot_scheduler: vector table with an output
// scoreboard, plus hand-written clear-sweep and reset-mid-clear sequences.
module tb_vga_plot_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       clear_start;
    logic [2:0] clear_colour;
    logic       req0, req1;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] col0, col1;
    logic       ack0, ack1, busy, clear_done, vga_write;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       r0;
        logic [7:0] x0;
        logic [6:0] y0;
        logic [2:0] c0;
        logic       r1;
        logic [7:0] x1;
        logic [6:0] y1;
        logic [2:0] c1;
        logic       ea0;
        logic       ea1;
        logic       ew;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
    } vec_t;

    typedef struct {
        logic       w;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[17];

    vga_plot_scheduler #(
        .SCREEN_W(160),
        .SCREEN_H(120),
        .X_W(8),
        .Y_W(7),
        .COLOUR_W(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .clear_start(clear_start),
        .clear_colour(clear_colour),
        .req0(req0),
        .x0(x0),
        .y0(y0),
        .col0(col0),
        .ack0(ack0),
        .req1(req1),
        .x1(x1),
        .y1(y1),
        .col1(col1),
        .ack1(ack1),
        .busy(busy),
        .clear_done(clear_done),
        .vga_x(vga_x),
        .vga_y(vga_y),
        .vga_colour(vga_colour),
        .vga_write(vga_write)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r0, input int ax0, input int ay0, input int ac0,
                                input logic r1, input int ax1, input int ay1, input int ac1,
                                input logic ea0, input logic ea1, input logic ew,
                                input int ex, input int ey, input int ec);
        vec_t v;
        v.r0 = r0;  v.x0 = 8'(ax0); v.y0 = 7'(ay0); v.c0 = 3'(ac0);
        v.r1 = r1;  v.x1 = 8'(ax1); v.y1 = 7'(ay1); v.c1 = 3'(ac1);
        v.ea0 = ea0; v.ea1 = ea1; v.ew = ew;
        v.ex = 8'(ex); v.ey = 7'(ey); v.ec = 3'(ec);
        return v;
    endfunction

    task automatic pop_and_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_write"}, 32'(vga_write), 32'(e.w));
            if (e.w) begin
                check({tag, "_x"}, 32'(vga_x), 32'(e.x));
                check({tag, "_y"}, 32'(vga_y), 32'(e.y));
                check({tag, "_colour"}, 32'(vga_colour), 32'(e.c));
            end
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        exp_t e;
        string tag;
        tag = $sformatf("vec%0d", idx);
        req0 = v.r0; x0 = v.x0; y0 = v.y0; col0 = v.c0;
        req1 = v.r1; x1 = v.x1; y1 = v.y1; col1 = v.c1;
        #1;
        check({tag, "_ack0"}, 32'(ack0), 32'(v.ea0));
        check({tag, "_ack1"}, 32'(ack1), 32'(v.ea1));
        e.w = v.ew; e.x = v.ex; e.y = v.ey; e.c = v.ec;
        sb.push_back(e);
        @(posedge clock); #1;
        pop_and_compare(tag);
    endtask

    initial begin
        int pix, busy_cnt, done_cnt, errs, n, acked, done_seen;
        exp_t e;

        // r0 x0 y0 c0 | r1 x1 y1 c1 | ack0 ack1 write | x y colour
        tbl[0]  = mk(0,   0,   0, 0,  0,   0,   0, 0,  0, 0, 0,    0,   0, 0);
        tbl[1]  = mk(1,  10,  20, 5,  0,   0,   0, 0,  1, 0, 1,   10,  20, 5);
        tbl[2]  = mk(0,   0,   0, 0,  1,  30,  40, 6,  0, 1, 1,   30,  40, 6);
        tbl[3]  = mk(1,   1,   2, 1,  1,   3,   4, 2,  1, 0, 1,    1,   2, 1);
        tbl[4]  = mk(1,   5,   6, 3,  1,   3,   4, 2,  0, 1, 1,    3,   4, 2);
        tbl[5]  = mk(1,   5,   6, 3,  1,   7,   8, 4,  1, 0, 1,    5,   6, 3);
        tbl[6]  = mk(1,   9,  10, 6,  1,   7,   8, 4,  0, 1, 1,    7,   8, 4);
        tbl[7]  = mk(1,   9,  10, 6,  1,  11,  12, 7,  1, 0, 1,    9,  10, 6);
        tbl[8]  = mk(1,  13,  14, 0,  1,  11,  12, 7,  0, 1, 1,   11,  12, 7);
        tbl[9]  = mk(0,   0,   0, 0,  1, 160,   5, 2,  0, 1, 0,    0,   0, 0);
        tbl[10] = mk(0,   0,   0, 0,  1,   3, 120, 2,  0, 1, 0,    0,   0, 0);
        tbl[11] = mk(0,   0,   0, 0,  1, 159, 119, 5,  0, 1, 1,  159, 119, 5);
        tbl[12] = mk(1, 200,   0, 1,  0,   0,   0, 0,  1, 0, 0,    0,   0, 0);
        tbl[13] = mk(1,   0,   0, 1,  1,   1,   1, 2,  0, 1, 1,    1,   1, 2);
        tbl[14] = mk(1,   0,   0, 1,  0,   0,   0, 0,  1, 0, 1,    0,   0, 1);
        tbl[15] = mk(1,   2,   3, 4,  0,   0,   0, 0,  1, 0, 1,    2,   3, 4);
        tbl[16] = mk(0,   0,   0, 0,  0,   0,   0, 0,  0, 0, 0,    0,   0, 0);

        reset = 1'b1; clear_start = 1'b0; clear_colour = '0;
        req0 = 1'b0; x0 = '0; y0 = '0; col0 = '0;
        req1 = 1'b0; x1 = '0; y1 = '0; col1 = '0;

        // T1: reset
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("t1_vga_write", 32'(vga_write), 0);
        check("t1_busy", 32'(busy), 0);
        check("t1_clear_done", 32'(clear_done), 0);
        check("t1_ack0", 32'(ack0), 0);
        check("t1_ack1", 32'(ack1), 0);

        // T2, T3, T5 and round-robin / throughput vectors
        foreach (tbl[i]) apply_vec(tbl[i], i);

        // T4: clear wins over a simultaneous request; request waits for the sweep
        clear_start = 1'b1; clear_colour = 3'b001;
        req0 = 1'b1; x0 = 8'd50; y0 = 7'd60; col0 = 3'd2;
        #1;
        check("t4_start_ack0", 32'(ack0), 0);
        @(posedge clock); #1;
        clear_start = 1'b0;
        check("t4_busy_rise", 32'(busy), 1);
        check("t4_no_plot_on_start", 32'(vga_write), 0);
        pix = 0; busy_cnt = 1; done_cnt = 0; errs = 0; acked = 0;
        for (int k = 0; k < 19400; k++) begin
            @(posedge clock); #1;
            clear_start = 1'b0;
            if (busy) busy_cnt++;
            if (clear_done) done_cnt++;
            if (vga_write) begin
                if (vga_x !== 8'(pix % 160) || vga_y !== 7'(pix / 160) || vga_colour !== 3'd1) begin
                    if (errs < 4)
                        $display("FAIL t4_pixel %0d: got (%0d,%0d,%0d), expected (%0d,%0d,1)",
                                 pix, vga_x, vga_y, vga_colour, pix % 160, pix / 160);
                    errs++;
                end
                pix++;
            end else if (pix < 19200) begin
                errs++;
            end
            if (ack0 && busy) errs++;
            if (pix == 5000) begin
                clear_start = 1'b1;
                clear_colour = 3'd7;
            end
            if (ack0) begin
                acked = 1;
                break;
            end
        end
        check("t4_acked_after_clear", 32'(acked), 1);
        check("t4_busy_cycles", 32'(busy_cnt), 19200);
        check("t4_pixels", 32'(pix), 19200);
        check("t4_done_pulses", 32'(done_cnt), 1);
        check("t4_sweep_errors", 32'(errs), 0);
        e.w = 1'b1; e.x = 8'd50; e.y = 7'd60; e.c = 3'd2;
        sb.push_back(e);
        @(posedge clock); #1;
        req0 = 1'b0;
        check("t4_done_one_cycle", 32'(clear_done), 0);
        pop_and_compare("t4_req0");

        // T6: reset during a sweep abandons it
        clear_start = 1'b1; clear_colour = 3'd6;
        @(posedge clock); #1;
        clear_start = 1'b0;
        check("t6_busy", 32'(busy), 1);
        pix = 0; n = 0;
        while (pix < 500 && n < 1000) begin
            @(posedge clock); #1;
            n++;
            if (vga_write) pix++;
        end
        check("t6_reached_500", 32'(pix), 500);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("t6_busy_after_reset", 32'(busy), 0);
        check("t6_write_after_reset", 32'(vga_write), 0);
        check("t6_done_after_reset", 32'(clear_done), 0);
        done_seen = 0;
        repeat (3) begin
            @(posedge clock); #1;
            if (clear_done || vga_write || busy) done_seen++;
        end
        check("t6_quiet_after_reset", 32'(done_seen), 0);
        clear_start = 1'b1; clear_colour = 3'd3;
        @(posedge clock); #1;
        clear_start = 1'b0;
        @(posedge clock); #1;
        check("t6_restart_write", 32'(vga_write), 1);
        check("t6_restart_x", 32'(vga_x), 0);
        check("t6_restart_y", 32'(vga_y), 0);
        check("t6_restart_colour", 32'(vga_colour), 3);
        @(posedge clock); #1;
        check("t6_second_x", 32'(vga_x), 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
